// File: rtl/pipe_mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: op encoding, FSM states, error codes.
// Latency: n/a (constants and pure combinational helpers only).
// Backpressure: n/a.
package pipe_mem_stage_pkg;

  // EX -> MEM operation encoding; any value above OP_SW is treated as OP_NONE.
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  function automatic logic [3:0] op_norm(input logic [3:0] op);
    return (op > OP_SW) ? OP_NONE : op;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    return (is_half(op) && addr_lo[0]) || (is_word(op) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Bundle of the MEM stage's three handshakes: EX->MEM, MEM<->data memory, MEM->WB.
// slave  = the MEM stage itself (accepts EX ops, issues memory requests, sources WB).
// master = the environment around it (EX stage, data memory, WB stage).
interface pipe_mem_stage_if;
  // EX -> MEM
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_wb_e;
  logic [4:0]  ex_idx;
  // MEM <-> data memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // MEM -> WB
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_e;
  logic [31:0] wb_data;
  logic [4:0]  wb_idx;
  // status
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_wdata, ex_wb_e, ex_idx,
    output ex_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata,
    output wb_valid, wb_e, wb_data, wb_idx,
    input  wb_ready,
    output err, err_code
  );

  modport master (
    output ex_valid, ex_op, ex_addr, ex_wdata, ex_wb_e, ex_idx,
    input  ex_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata,
    input  wb_valid, wb_e, wb_data, wb_idx,
    output wb_ready,
    input  err, err_code
  );
endinterface

// File: rtl/pipe_mem_stage_lane_align.sv
// Byte-lane steering for the MEM stage: byte enables, store-data replication, load extend.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: op (normalised op), addr_lo (addr[1:0]), wdata/rdata in; be, wdata_lanes, rdata_ext out.
module mem_lane_align
  import pipe_mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel = rdata[7:0];
    case (addr_lo)
      2'd1:    bsel = rdata[15:8];
      2'd2:    bsel = rdata[23:16];
      2'd3:    bsel = rdata[31:24];
      default: bsel = rdata[7:0];
    endcase
    hsel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    case (op)
      OP_LB: begin
        be        = 4'b0001 << addr_lo;
        rdata_ext = {{24{bsel[7]}}, bsel};
      end
      OP_LBU: begin
        be        = 4'b0001 << addr_lo;
        rdata_ext = {24'd0, bsel};
      end
      OP_LH: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext = {{16{hsel[15]}}, hsel};
      end
      OP_LHU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext = {16'd0, hsel};
      end
      OP_LW: be = 4'b1111;
      OP_SB: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be          = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
      end
      OP_SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// MIPS MEM stage: passes ALU results through, performs byte/half/word loads/stores via req/ack.
// Latency: non-memory ops 1 cycle; memory ops 1 cycle + memory latency (abort after TIMEOUT).
// Backpressure: ex_ready drops while an access is in flight or the WB register is held.
// Ports: clk, rst (async, active-high); bus (slave): EX valid/ready in, data-memory req/ack,
//        WB valid/ready out with {wb_e, wb_data, wb_idx}, err pulse + sticky err_code.
module pipe_mem_stage
  import pipe_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic            clk,
  input  logic            rst,
  pipe_mem_stage_if.slave bus
);

  state_t      state, state_nxt;
  logic [TW-1:0] cnt;

  // Op latched at entry to ACCESS; drives the memory port for the whole access.
  logic [3:0]  acc_op;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_wb_e;
  logic [4:0]  acc_idx;

  logic [3:0]  in_op;
  logic        in_pass, in_mis, transfer;
  logic        acc_done, acc_timeout, mem_req_c;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  assign in_op    = op_norm(bus.ex_op);
  assign in_pass  = (in_op == OP_NONE);
  assign in_mis   = misaligned(in_op, bus.ex_addr[1:0]);

  assign bus.ex_ready = (state == S_IDLE) && (!bus.wb_valid || bus.wb_ready);
  assign transfer     = bus.ex_valid && bus.ex_ready;

  assign acc_done    = (state == S_ACCESS) && bus.mem_ack;
  // An ack in the final counted cycle still completes normally.
  assign acc_timeout = (state == S_ACCESS) && !bus.mem_ack && (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (transfer && !in_pass && !in_mis) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_req_c = 1'b1;
        if (acc_done || acc_timeout) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           cnt <= '0;
    else if ((state == S_ACCESS) && (state_nxt == S_ACCESS)) cnt <= cnt + 1'b1;
    else                                               cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_op    <= OP_NONE;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_wb_e  <= 1'b0;
      acc_idx   <= '0;
    end else if (transfer && !in_pass && !in_mis) begin
      acc_op    <= in_op;
      acc_addr  <= bus.ex_addr;
      acc_wdata <= bus.ex_wdata;
      acc_wb_e  <= bus.ex_wb_e;
      acc_idx   <= bus.ex_idx;
    end
  end

  mem_lane_align u_align (
    .op          (acc_op),
    .addr_lo     (acc_addr[1:0]),
    .wdata       (acc_wdata),
    .rdata       (bus.mem_rdata),
    .be          (lane_be),
    .wdata_lanes (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = is_store(acc_op);
  assign bus.mem_addr  = {acc_addr[31:2], 2'b00};
  assign bus.mem_be    = lane_be;
  assign bus.mem_wdata = lane_wdata;

  // Single output register. A load in the same cycle as a WB handshake wins over the clear.
  // No stall path is needed on completion: entry to ACCESS required a free register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_valid <= 1'b0;
      bus.wb_e     <= 1'b0;
      bus.wb_data  <= '0;
      bus.wb_idx   <= '0;
      bus.err      <= 1'b0;
      bus.err_code <= ERR_NONE;
    end else begin
      bus.err <= 1'b0;
      if (transfer && (in_pass || in_mis)) begin
        bus.wb_valid <= 1'b1;
        bus.wb_e     <= in_pass ? bus.ex_wb_e : 1'b0;
        bus.wb_data  <= bus.ex_addr;
        bus.wb_idx   <= bus.ex_idx;
        if (in_mis) begin
          bus.err      <= 1'b1;
          bus.err_code <= ERR_MISALIGN;
        end
      end else if (acc_done) begin
        bus.wb_valid <= 1'b1;
        bus.wb_e     <= is_store(acc_op) ? 1'b0 : acc_wb_e;
        bus.wb_data  <= is_store(acc_op) ? acc_addr : lane_rdata;
        bus.wb_idx   <= acc_idx;
      end else if (acc_timeout) begin
        bus.wb_valid <= 1'b1;
        bus.wb_e     <= 1'b0;
        bus.wb_data  <= acc_addr;
        bus.wb_idx   <= acc_idx;
        bus.err      <= 1'b1;
        bus.err_code <= ERR_TIMEOUT;
      end else if (bus.wb_valid && bus.wb_ready) begin
        bus.wb_valid <= 1'b0;
      end
    end
  end

endmodule
